// File: rtl/sim_irq_sched_if.sv
// sim_irq_sched_if: configuration write port and interrupt outputs of sim_irq_sched.
// cfg_sticky exists only when IRQ_SCHED_STICKY_EN is defined.
interface sim_irq_sched_if #(
  parameter int NUM_CH  = 8,
  parameter int CNT_W   = 64,
  parameter int PULSE_W = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic               cfg_en;
  logic               cfg_periodic;
  logic [CNT_W-1:0]   cfg_start;
  logic [PULSE_W-1:0] cfg_width;
  logic [CNT_W-1:0]   cfg_period;
`ifdef IRQ_SCHED_STICKY_EN
  logic               cfg_sticky;
`endif
  logic [NUM_CH-1:0]  irq_ack;
  logic [CNT_W-1:0]   sim_cycles;
  logic [NUM_CH-1:0]  ext_interrupt;
  logic [NUM_CH-1:0]  ch_busy;
  modport master (
`ifdef IRQ_SCHED_STICKY_EN
    output cfg_sticky,
`endif
    output cfg_we, cfg_ch, cfg_en, cfg_periodic, cfg_start, cfg_width, cfg_period, irq_ack,
    input  sim_cycles, ext_interrupt, ch_busy
  );
  modport slave (
`ifdef IRQ_SCHED_STICKY_EN
    input  cfg_sticky,
`endif
    input  cfg_we, cfg_ch, cfg_en, cfg_periodic, cfg_start, cfg_width, cfg_period, irq_ack,
    output sim_cycles, ext_interrupt, ch_busy
  );
endinterface

// File: rtl/sim_irq_sched.sv
// sim_irq_sched: free-running sim cycle counter plus NUM_CH programmable one-shot/periodic interrupt pulsers.
// IRQ_SCHED_STICKY_EN adds per-channel sticky outputs held until irq_ack.
module sim_irq_sched #(
  parameter int NUM_CH  = 8,
  parameter int CNT_W   = 64,
  parameter int PULSE_W = 16
) (
  input  logic           pll_cpu_clk,
  input  logic           pad_cpu_rst_b,
  sim_irq_sched_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW   = ((CNT_W > PULSE_W) ? CNT_W : PULSE_W) + 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HIGH} st_e;
  logic [CNT_W-1:0]  cyc_q;
  logic [NUM_CH-1:0] irq_v, busy_v;
  always_ff @(posedge pll_cpu_clk or negedge pad_cpu_rst_b)
    if (!pad_cpu_rst_b) cyc_q <= '0;
    else cyc_q <= cyc_q + CNT_W'(1);
  assign bus.sim_cycles    = cyc_q;
  assign bus.ext_interrupt = irq_v;
  assign bus.ch_busy       = busy_v;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    st_e                st_q, st_d;
    logic [CNT_W-1:0]   nf_q, nf_d, per_q, per_d;
    logic [PULSE_W-1:0] w_q, w_d, cnt_q, cnt_d, weff;
    logic               mode_q, mode_d, stk_q, stk_d, irq_q, irq_d;
    logic               wr, hit, stk_in, ack;
    logic [SW-1:0]      w1, pw, step;
    assign wr   = bus.cfg_we && (bus.cfg_ch == CH_W'(c));
    assign hit  = nf_q == cyc_q;
    assign weff = (w_q == '0) ? PULSE_W'(1) : w_q;
    // fire-to-fire distance never shorter than the pulse plus one low cycle
    assign w1   = SW'(weff) + SW'(1);
    assign pw   = SW'(per_q);
    assign step = (pw > w1) ? pw : w1;
`ifdef IRQ_SCHED_STICKY_EN
    assign stk_in = bus.cfg_sticky;
    assign ack    = bus.irq_ack[c];
`else
    assign stk_in = 1'b0;
    assign ack    = 1'b0;
`endif
    always_comb begin
      st_d   = st_q;
      nf_d   = nf_q;
      per_d  = per_q;
      w_d    = w_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      stk_d  = stk_q;
      irq_d  = irq_q & stk_q & ~ack;
      if (wr) begin
        st_d   = bus.cfg_en ? S_WAIT : S_IDLE;
        nf_d   = bus.cfg_start;
        per_d  = bus.cfg_period;
        w_d    = bus.cfg_width;
        mode_d = bus.cfg_periodic;
        stk_d  = stk_in;
        irq_d  = 1'b0;
      end else if (st_q == S_WAIT && hit) begin
        st_d  = S_HIGH;
        cnt_d = weff;
        irq_d = 1'b1;
      end else if (st_q == S_HIGH) begin
        cnt_d = cnt_q - PULSE_W'(1);
        irq_d = (cnt_q > PULSE_W'(1)) | stk_q;
        if (cnt_q <= PULSE_W'(1)) begin
          st_d = (mode_q && per_q != '0) ? S_WAIT : S_IDLE;
          nf_d = nf_q + step[CNT_W-1:0];
        end
      end
    end
    always_ff @(posedge pll_cpu_clk or negedge pad_cpu_rst_b)
      if (!pad_cpu_rst_b) begin
        st_q   <= S_IDLE;
        nf_q   <= '0;
        per_q  <= '0;
        w_q    <= '0;
        cnt_q  <= '0;
        mode_q <= 1'b0;
        stk_q  <= 1'b0;
        irq_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        nf_q   <= nf_d;
        per_q  <= per_d;
        w_q    <= w_d;
        cnt_q  <= cnt_d;
        mode_q <= mode_d;
        stk_q  <= stk_d;
        irq_q  <= irq_d;
      end
    assign irq_v[c]  = irq_q;
    assign busy_v[c] = st_q != S_IDLE;
  end
endmodule

// File: tb/tb_sim_irq_sched.sv
// tb_sim_irq_sched: directed scoreboard bench; every ext_interrupt transition is checked against a queued (cycle, value) pair.
module tb_sim_irq_sched;
  typedef struct {logic [7:0] cyc; logic [7:0] val;} ev_t;
  logic clk, rst_n, mon_en;
  logic [7:0] prev;
  ev_t exp_q[$];
  ev_t e_m;
  int total, bad;
  sim_irq_sched_if #(.NUM_CH(8), .CNT_W(8), .PULSE_W(16)) bus ();
  sim_irq_sched #(.NUM_CH(8), .CNT_W(8), .PULSE_W(16)) dut (
    .pll_cpu_clk(clk), .pad_cpu_rst_b(rst_n), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task push(input logic [7:0] c, input logic [7:0] v);
    exp_q.push_back('{c, v});
  endtask
  task chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task wait_cyc(input logic [7:0] v);
    int n = 0;
    while (bus.sim_cycles !== v && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.sim_cycles !== v) begin
      total++;
      bad++;
      $display("FAIL wait_cyc: sim_cycles=%h never reached %h", bus.sim_cycles, v);
    end
  endtask
  task wr(input logic [2:0] ch, input logic en, input logic per, input logic [7:0] start,
          input logic [15:0] width, input logic [7:0] period, input logic stk);
    bus.cfg_we = 1; bus.cfg_ch = ch; bus.cfg_en = en; bus.cfg_periodic = per;
    bus.cfg_start = start; bus.cfg_width = width; bus.cfg_period = period;
`ifdef IRQ_SCHED_STICKY_EN
    bus.cfg_sticky = stk;
`else
    if (stk) $display("note: sticky request ignored in this build");
`endif
    @(posedge clk);
    #1;
    bus.cfg_we = 0;
  endtask
  always @(negedge clk)
    if (mon_en && bus.ext_interrupt !== prev) begin
      prev = bus.ext_interrupt;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL irq_edge: unexpected irq=%h at cyc=%h", bus.ext_interrupt, bus.sim_cycles);
      end else begin
        e_m = exp_q.pop_front();
        if (bus.sim_cycles !== e_m.cyc || bus.ext_interrupt !== e_m.val) begin
          bad++;
          $display("FAIL irq_edge: got cyc=%h irq=%h want cyc=%h irq=%h",
                   bus.sim_cycles, bus.ext_interrupt, e_m.cyc, e_m.val);
        end
      end
    end
  initial begin
    rst_n = 0; mon_en = 0; prev = 0; total = 0; bad = 0;
    bus.cfg_we = 0; bus.cfg_ch = 0; bus.cfg_en = 0; bus.cfg_periodic = 0;
    bus.cfg_start = 0; bus.cfg_width = 0; bus.cfg_period = 0; bus.irq_ack = 0;
`ifdef IRQ_SCHED_STICKY_EN
    bus.cfg_sticky = 0;
`endif
    #12 rst_n = 1;
    mon_en = 1;
    @(posedge clk);
    #1;
    // reset in the middle of a ch0 pulse
    wait_cyc(8'h02);
    wr(0, 1, 0, 8'h08, 16'd4, 8'd0, 0);
    push(8'h09, 8'h01);
    wait_cyc(8'h0B);
    #1 rst_n = 0;
    push(8'h00, 8'h00);
    #1;
    chk("rst_cycles", bus.sim_cycles, 0);
    chk("rst_busy", bus.ch_busy, 0);
    chk("rst_irq", bus.ext_interrupt, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    repeat (4) @(posedge clk);
    #1;
    chk("cnt_after_reset", bus.sim_cycles, 5);
    // one-shot, width 16
    wr(0, 1, 0, 8'h20, 16'h10, 8'd0, 0);
    push(8'h21, 8'h01);
    push(8'h31, 8'h00);
    wait_cyc(8'h30);
    chk("oneshot_busy_hi", bus.ch_busy[0], 1);
    chk("oneshot_irq_hi", bus.ext_interrupt[0], 1);
    wait_cyc(8'h31);
    chk("oneshot_busy_lo", bus.ch_busy[0], 0);
    // simultaneous fires, then abort by disarm
    wait_cyc(8'h32);
    wr(1, 1, 0, 8'h40, 16'd1, 8'd0, 0);
    wr(5, 1, 0, 8'h40, 16'd1, 8'd0, 0);
    push(8'h41, 8'h22);
    push(8'h42, 8'h00);
    wait_cyc(8'h42);
    wr(1, 1, 0, 8'h48, 16'd8, 8'd0, 0);
    push(8'h49, 8'h02);
    wait_cyc(8'h44);
    wr(4, 1, 0, 8'h55, 16'd2, 8'd0, 0);
    wait_cyc(8'h4B);
    push(8'h4C, 8'h00);
    wr(1, 0, 0, 8'h00, 16'd1, 8'd0, 0);
    chk("disarm_busy", bus.ch_busy[1], 0);
    // rewrite on the exact fire cycle: write wins
    wait_cyc(8'h55);
    wr(4, 1, 0, 8'h60, 16'd2, 8'd0, 0);
    push(8'h61, 8'h10);
    push(8'h63, 8'h00);
    // periodic, period 10 then period 2 (clamped to 4)
    wait_cyc(8'h5A);
    wr(2, 1, 1, 8'h64, 16'd3, 8'd10, 0);
    push(8'h65, 8'h04); push(8'h68, 8'h00);
    push(8'h6F, 8'h04); push(8'h72, 8'h00);
    push(8'h79, 8'h04); push(8'h7C, 8'h00);
    wait_cyc(8'h7D);
    wr(2, 1, 1, 8'h80, 16'd3, 8'd2, 0);
    push(8'h81, 8'h04); push(8'h84, 8'h00);
    push(8'h85, 8'h04); push(8'h88, 8'h00);
    push(8'h89, 8'h04); push(8'h8C, 8'h00);
    wait_cyc(8'h8C);
    wr(2, 0, 1, 8'h00, 16'd3, 8'd2, 0);
    chk("periodic_stop_busy", bus.ch_busy[2], 0);
    // width 0 behaves as width 1
    wr(6, 1, 0, 8'h90, 16'd0, 8'd0, 0);
    push(8'h91, 8'h40);
    push(8'h92, 8'h00);
    // passed start fires only after counter wrap; periodic next_fire wraps
    wait_cyc(8'h93);
    wr(7, 1, 0, 8'h02, 16'd1, 8'd0, 0);
    wr(3, 1, 1, 8'hF0, 16'd2, 8'h20, 0);
    push(8'hF1, 8'h08); push(8'hF3, 8'h00);
    push(8'h03, 8'h80); push(8'h04, 8'h00);
    push(8'h11, 8'h08); push(8'h13, 8'h00);
    wait_cyc(8'h14);
    wr(3, 0, 0, 8'h00, 16'd1, 8'd0, 0);
    // sticky request on ch3
    wr(3, 1, 0, 8'h20, 16'd2, 8'd0, 1);
    push(8'h21, 8'h08);
`ifdef IRQ_SCHED_STICKY_EN
    push(8'h41, 8'h00);
`else
    push(8'h23, 8'h00);
`endif
    wait_cyc(8'h40);
    bus.irq_ack = 8'h08;
    @(posedge clk);
    #1 bus.irq_ack = 0;
    wait_cyc(8'h48);
    chk("final_busy", bus.ch_busy, 0);
    chk("final_irq", bus.ext_interrupt, 0);
    chk("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
